// File: rtl/mod_counter.sv
// Up/down modulo-(MAX+1) counter with load, clear, wrap or saturate behaviour,
// registered carry/borrow pulses and a combinational terminal flag for cascading.
module mod_counter #(
    parameter int WIDTH    = 3,
    parameter int MAX      = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             co,
    output logic             bo,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(1'b0);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1'b1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             co_q;
    logic             co_d;
    logic             bo_q;
    logic             bo_d;

    // Next-state: clear beats load beats count enable
    always_comb begin
        count_d = count_q;
        co_d    = 1'b0;
        bo_d    = 1'b0;
        if (clr) begin
            count_d = ZERO_V;
        end else if (ld) begin
            count_d = (ld_val > MAX_V) ? MAX_V : ld_val;
        end else if (en) begin
            if (up_dn) begin
                // >= keeps the limit check safe even if MAX is below the full range
                if (count_q >= MAX_V) begin
                    co_d    = 1'b1;
                    count_d = SATURATE ? MAX_V : ZERO_V;
                end else begin
                    count_d = count_q + ONE_V;
                end
            end else begin
                if (count_q == ZERO_V) begin
                    bo_d    = 1'b1;
                    count_d = SATURATE ? ZERO_V : MAX_V;
                end else begin
                    count_d = count_q - ONE_V;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // State register with synchronous reset overriding every other operation
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ZERO_V;
            co_q    <= 1'b0;
            bo_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            co_q    <= co_d;
            bo_q    <= bo_d;
        end
    end

    // Terminal flag stays combinational so tc & en can feed the next stage same-cycle
    always_comb begin
        if (up_dn) begin
            tc = (count_q == MAX_V);
        end else begin
            tc = (count_q == ZERO_V);
        end
    end

    assign count = count_q;
    assign co    = co_q;
    assign bo    = bo_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench: wrap, reduced-MAX and saturating counters against an
// arithmetic reference model, directed corner steps, random traffic and a cascade.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst, clr, ld, en, up_dn;
    logic [2:0] ld_val;
    logic       rst_c, en_c;

    logic [2:0] count_def, count_m5, count_sat, count_lo, count_hi;
    logic       co_def, bo_def, tc_def;
    logic       co_m5, bo_m5, tc_m5;
    logic       co_sat, bo_sat, tc_sat;
    logic       co_lo, bo_lo, tc_lo, co_hi, bo_hi, tc_hi;
    logic       en_hi;

    int total = 0;
    int bad   = 0;

    int m_def, m_m5, m_sat;
    bit eco_def, ebo_def, eco_m5, ebo_m5, eco_sat, ebo_sat;

    always #5 clk = ~clk;

    mod_counter u_def (.clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en),
                       .up_dn(up_dn), .count(count_def), .co(co_def), .bo(bo_def), .tc(tc_def));
    mod_counter #(.WIDTH(3), .MAX(5)) u_m5 (.clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
                       .en(en), .up_dn(up_dn), .count(count_m5), .co(co_m5), .bo(bo_m5), .tc(tc_m5));
    mod_counter #(.SATURATE(1'b1)) u_sat (.clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
                       .en(en), .up_dn(up_dn), .count(count_sat), .co(co_sat), .bo(bo_sat), .tc(tc_sat));

    assign en_hi = tc_lo & en_c;
    mod_counter u_lo (.clk(clk), .rst(rst_c), .clr(1'b0), .ld(1'b0), .ld_val(3'b000), .en(en_c),
                      .up_dn(1'b1), .count(count_lo), .co(co_lo), .bo(bo_lo), .tc(tc_lo));
    mod_counter u_hi (.clk(clk), .rst(rst_c), .clr(1'b0), .ld(1'b0), .ld_val(3'b000), .en(en_hi),
                      .up_dn(1'b1), .count(count_hi), .co(co_hi), .bo(bo_hi), .tc(tc_hi));

    // Reference: a counter over the ring 0..maxv, stepping by +/-1 modulo maxv+1
    function automatic void mstep(input int maxv, input bit sat, inout int c,
                                  output bit eco, output bit ebo);
        eco = 1'b0;
        ebo = 1'b0;
        if (rst || clr) c = 0;
        else if (ld) c = (int'(ld_val) > maxv) ? maxv : int'(ld_val);
        else if (en && up_dn) begin
            eco = (c == maxv);
            if (!(sat && eco)) c = (c + 1) % (maxv + 1);
        end else if (en) begin
            ebo = (c == 0);
            if (!(sat && ebo)) c = (c + maxv) % (maxv + 1);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [2:0] c, input logic co, input logic bo,
                            input logic tc, input int mc, input bit eco, input bit ebo, input int maxv);
        chk({tag, "_count"}, 32'(c), 32'(mc));
        chk({tag, "_co"}, 32'(co), 32'(eco));
        chk({tag, "_bo"}, 32'(bo), 32'(ebo));
        chk({tag, "_tc"}, 32'(tc), 32'(up_dn ? (mc == maxv) : (mc == 0)));
        chk({tag, "_co_bo_excl"}, 32'(co & bo), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        mstep(7, 1'b0, m_def, eco_def, ebo_def);
        mstep(5, 1'b0, m_m5, eco_m5, ebo_m5);
        mstep(7, 1'b1, m_sat, eco_sat, ebo_sat);
        #1;
        chk_inst("def", count_def, co_def, bo_def, tc_def, m_def, eco_def, ebo_def, 7);
        chk_inst("m5", count_m5, co_m5, bo_m5, tc_m5, m_m5, eco_m5, ebo_m5, 5);
        chk_inst("sat", count_sat, co_sat, bo_sat, tc_sat, m_sat, eco_sat, ebo_sat, 7);
    endtask

    initial begin
        int exp31 [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        int hico;
        m_def = 0; m_m5 = 0; m_sat = 0;
        rst = 1'b1; clr = 1'b0; ld = 1'b0; ld_val = 3'd0; en = 1'b0; up_dn = 1'b1;
        rst_c = 1'b1; en_c = 1'b0;

        // Reset state and tc = ~up_dn after reset
        tick();
        chk("rst_count", 32'(count_def), 32'd0);
        up_dn = 1'b0; #1;
        chk("rst_tc_down", 32'(tc_def), 32'd1);
        up_dn = 1'b1; #1;
        chk("rst_tc_up", 32'(tc_def), 32'd0);

        // Up-count wrap on the default instance
        rst = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("wrap_seq", 32'(count_def), 32'(exp31[i]));
            chk("wrap_co", 32'(co_def), 32'(i == 7));
        end

        // Down-count from 0 with MAX=5
        rst = 1'b1; en = 1'b0; tick();
        rst = 1'b0; en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("m5_down", 32'(count_m5), 32'(5 - i));
            chk("m5_bo", 32'(bo_m5), 32'(i == 0));
        end

        // Load clamping and load over enable
        en = 1'b0; ld = 1'b1; ld_val = 3'd7; tick();
        chk("m5_ld_clamp", 32'(count_m5), 32'd5);
        en = 1'b1; ld_val = 3'd2; tick();
        chk("m5_ld_over_en", 32'(count_m5), 32'd2);

        // Saturation at 7, then step down
        ld_val = 3'd7; en = 1'b0; tick();
        ld = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_hold", 32'(count_sat), 32'd7);
            chk("sat_co", 32'(co_sat), 32'd1);
        end
        up_dn = 1'b0; tick();
        chk("sat_down", 32'(count_sat), 32'd6);
        chk("sat_down_co", 32'(co_sat), 32'd0);

        // clr over ld/en, rst over ld
        ld = 1'b1; ld_val = 3'd4; en = 1'b0; tick();
        clr = 1'b1; en = 1'b1; tick();
        chk("clr_prio", 32'(count_def), 32'd0);
        clr = 1'b0; ld_val = 3'd5; tick();
        rst = 1'b1; tick();
        chk("rst_prio", 32'(count_def), 32'd0);

        // Reset mid-count discards the step
        rst = 1'b0; ld = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        chk("post_rst_step", 32'(count_def), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            clr    = ($urandom_range(0, 19) == 0);
            ld     = ($urandom_range(0, 7) == 0);
            ld_val = 3'($urandom_range(0, 7));
            en     = ($urandom_range(0, 3) != 0);
            up_dn  = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0;

        // Two-stage cascade walks 0..63 and wraps once
        @(posedge clk); #1;
        rst_c = 1'b0; en_c = 1'b1;
        chk("casc_reset", 32'({count_hi, count_lo}), 32'd0);
        hico = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            chk("casc_val", 32'({count_hi, count_lo}), 32'(k % 64));
            chk("casc_hi_co", 32'(co_hi), 32'(k == 64));
            if (co_hi) hico++;
        end
        en_c = 1'b0;
        chk("casc_hi_co_once", 32'(hico), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits; SHALL be >= 1.
REQ-002 Parameter MAX, default 2**WIDTH-1: terminal value; SHALL satisfy 1 <= MAX <= 2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap mode, 1 = saturate mode.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clr  input  1  synchronous clear of count, active-high.
REQ-007 ld  input  1  synchronous load strobe, active-high.
REQ-008 ld_val  input  WIDTH  load value.
REQ-009 en  input  1  count enable, active-high.
REQ-010 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 count  output  WIDTH  registered current count.
REQ-012 co  output  1  registered carry pulse (up overflow event).
REQ-013 bo  output  1  registered borrow pulse (down underflow event).
REQ-014 tc  output  1  combinational terminal flag: high when (up_dn=1 and count=MAX) or (up_dn=0 and count=0).

Function
REQ-015 Priority per edge SHALL be rst > clr > ld > en; only the highest active operation takes effect.
REQ-016 clr=1: count <= 0; co <= 0; bo <= 0.
REQ-017 ld=1: count <= ld_val if ld_val <= MAX, else MAX (clamped); co <= 0; bo <= 0.
REQ-018 en=1, up_dn=1, count < MAX: count <= count+1; co <= 0.
REQ-019 en=1, up_dn=1, count = MAX, SATURATE=0: count <= 0; co <= 1 for exactly that one cycle.
REQ-020 en=1, up_dn=0, count > 0: count <= count-1; bo <= 0.
REQ-021 en=1, up_dn=0, count = 0, SATURATE=0: count <= MAX; bo <= 1 for exactly that one cycle.
REQ-022 SATURATE=1, enabled step at the limit (MAX up, 0 down): count holds; co (up) or bo (down) <= 1 for that cycle; repeated attempts re-assert each cycle.
REQ-023 en=0 and no clr/ld/rst: count holds; co <= 0; bo <= 0.
REQ-024 co and bo SHALL never both be 1 in the same cycle.
REQ-025 Arithmetic SHALL be WIDTH bits wide with explicit compare to MAX; count SHALL never exceed MAX, including when MAX < 2**WIDTH-1.
REQ-026 up_dn changes take effect on the next enabled edge; no extra latency.
REQ-027 Cascading: tc & en of stage N SHALL be usable as en of stage N+1 with no added cycle.

Reset
REQ-028 rst=1: count <= 0, co <= 0, bo <= 0 on the same edge, overriding clr, ld and en.
REQ-029 rst asserted mid-count SHALL discard the pending step; first step after release counts from 0.
REQ-030 tc after reset SHALL equal ~up_dn (count=0).

Verification
REQ-031 Defaults, rst then en=1 up_dn=1 for 9 cycles -> count 1..7, 0, 1; co=1 only in the cycle count=0 first appears.
REQ-032 MAX=5, up_dn=0 from 0 -> count 5, bo=1 one cycle; then 4,3,2,1,0 with bo=0.
REQ-033 MAX=5, ld=1 ld_val=7 -> count=5; ld=1 and en=1 together with ld_val=2 -> count=2, no step.
REQ-034 SATURATE=1 defaults, count=7, en=1 up_dn=1 for 3 cycles -> count stays 7, co=1 each cycle; up_dn=0 -> 6, co=0.
REQ-035 clr=1 with ld=1 and en=1 at count=4 -> count=0; rst=1 with clr=0, ld=1 -> count=0, co=bo=0.
REQ-036 Two cascaded defaults instances, en=1 for 64 cycles -> combined value {hi,lo} walks 0..63 then 0, hi co=1 once.
